// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        DRAIN
    } fetch_state_t;

    typedef enum logic [1:0] {
        RK_BRANCH = 2'b00,
        RK_JUMP   = 2'b01,
        RK_REG    = 2'b10,
        RK_RSVD   = 2'b11
    } redirect_kind_t;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect target: PC-relative branch, pseudo-direct jump or register.
module branch_target_gen
    import mips_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [31:0] base,
    input  logic [25:0] imm,
    input  logic [31:0] reg_val,
    output logic [31:0] target
);

    redirect_kind_t k;
    assign k = redirect_kind_t'(kind);

    always_comb begin
        target = {reg_val[31:2], 2'b00};
        unique case (k)
            RK_BRANCH: target = base + {{14{imm[15]}}, imm[15:0], 2'b00};
            RK_JUMP:   target = {base[31:28], imm, 2'b00};
            default:   target = {reg_val[31:2], 2'b00};
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ack to imem and valid/ready to decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_base,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_reg
);

    fetch_state_t state, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  instr_q, ipc_q;
    logic [31:0]  target;
    logic         capture;

    branch_target_gen u_tgt (
        .kind    (redirect_kind),
        .base    (redirect_base),
        .imm     (redirect_imm),
        .reg_val (redirect_reg),
        .target  (target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // A redirect while a request is outstanding parks in pend_q (DRAIN) so imem_addr stays put until the ack.
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        pend_d  = pend_q;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                state_d = FETCH;
                if (redirect) pc_d = target;
            end
            FETCH: begin
                if (imem_ack && !redirect) begin
                    capture = 1'b1;
                    pc_d    = pc_q + 32'(INSTR_BYTES);
                    state_d = VALID;
                end else if (imem_ack) begin
                    pc_d = target;
                end else if (redirect) begin
                    pend_d  = target;
                    state_d = DRAIN;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (if_ready) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            if (capture) begin
                instr_q <= imem_rdata;
                ipc_q   <= pc_q;
            end
        end
    end

    assign imem_req    = (state == FETCH) || (state == DRAIN);
    assign imem_addr   = pc_q;
    assign if_valid    = (state == VALID);
    assign if_instr    = instr_q;
    assign if_pc       = ipc_q;
    assign if_pc_plus4 = ipc_q + 32'(INSTR_BYTES);

endmodule
